// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// datapath select codes, data-processing commands and condition codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH
  } state_t;

  localparam logic [1:0] IMM_DP     = 2'b00;
  localparam logic [1:0] IMM_MEM    = 2'b01;
  localparam logic [1:0] IMM_BR     = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_AND    = 2'b10;
  localparam logic [1:0] ALU_ORR    = 2'b11;

  localparam logic [1:0] OP_DP      = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BR      = 2'b10;

  localparam logic [3:0] CMD_AND    = 4'b0000;
  localparam logic [3:0] CMD_SUB    = 4'b0010;
  localparam logic [3:0] CMD_ADD    = 4'b0100;
  localparam logic [3:0] CMD_CMP    = 4'b1010;
  localparam logic [3:0] CMD_ORR    = 4'b1100;

  localparam logic [3:0] COND_EQ    = 4'b0000;
  localparam logic [3:0] COND_NE    = 4'b0001;
  localparam logic [3:0] COND_CS    = 4'b0010;
  localparam logic [3:0] COND_CC    = 4'b0011;
  localparam logic [3:0] COND_MI    = 4'b0100;
  localparam logic [3:0] COND_PL    = 4'b0101;
  localparam logic [3:0] COND_VS    = 4'b0110;
  localparam logic [3:0] COND_VC    = 4'b0111;
  localparam logic [3:0] COND_HI    = 4'b1000;
  localparam logic [3:0] COND_LS    = 4'b1001;
  localparam logic [3:0] COND_GE    = 4'b1010;
  localparam logic [3:0] COND_LT    = 4'b1011;
  localparam logic [3:0] COND_GT    = 4'b1100;
  localparam logic [3:0] COND_LE    = 4'b1101;
  localparam logic [3:0] COND_AL    = 4'b1110;
  localparam logic [3:0] COND_NV    = 4'b1111;

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
           (cmd == CMD_ORR) || (cmd == CMD_CMP);
  endfunction

  function automatic logic [1:0] dp_alu_control(input logic [3:0] cmd);
    logic [1:0] ctl;
    ctl = ALU_ADD;
    unique case (cmd)
      CMD_SUB, CMD_CMP: ctl = ALU_SUB;
      CMD_AND:          ctl = ALU_AND;
      CMD_ORR:          ctl = ALU_ORR;
      default:          ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_cond_check.sv
// Condition-code evaluator: ARM cond field against NZCV. Pure combinational,
// shared with the pipelined core.
module cond_check (
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_ex
);
  import mc_ctrl_pkg::*;

  logic n, z, c, v;

  assign n = nzcv[3];
  assign z = nzcv[2];
  assign c = nzcv[1];
  assign v = nzcv[0];

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle ARM-subset core: sequences fetch, decode,
// execute, memory and writeback, and owns the NZCV flag register.
module multicycle_ctrl #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] instr,
  input  logic [3:0]  alu_flags,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  imm_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_control,
  output logic [1:0]  result_src,
  output logic [3:0]  flags,
  output logic        illegal
);
  import mc_ctrl_pkg::*;

  state_t      state, state_next;
  logic [3:0]  cond, rd, cmd;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  flags_q;
  logic        cond_ex, cond_ex_q;
  logic        is_cmp, is_arith, rd_pc, dec_illegal, in_exec, flag_load;
  logic        unused_rn;

  logic        pc_write_d, ir_write_d, adr_src_d, mem_write_d, reg_write_d;
  logic        alu_src_a_d, illegal_d;
  logic [1:0]  imm_src_d, alu_src_b_d, alu_control_d, result_src_d;

  assign cond      = instr[19:16];
  assign op        = instr[15:14];
  assign funct     = instr[13:8];
  assign rd        = instr[3:0];
  assign cmd       = funct[4:1];
  assign unused_rn = ^instr[7:4];

  assign is_cmp      = (cmd == CMD_CMP);
  assign is_arith    = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
  assign rd_pc       = (rd == 4'd15);
  assign dec_illegal = (cond == COND_NV) || (op == 2'b11) ||
                       ((op == OP_DP) && !cmd_supported(cmd));
  assign in_exec     = (state == EXECUTER) || (state == EXECUTEI);
  assign flag_load   = in_exec && cond_ex && (funct[0] || is_cmp);

  cond_check u_cond_check (
    .cond    (cond),
    .nzcv    (flags_q),
    .cond_ex (cond_ex)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  // cond_ex is captured in EXECUTE so ALUWB sees the pre-update flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= FLAG_RST;
      cond_ex_q <= 1'b0;
    end else if (in_exec) begin
      cond_ex_q <= cond_ex;
      if (flag_load) begin
        flags_q[3:2] <= alu_flags[3:2];
        if (is_arith) flags_q[1:0] <= alu_flags[1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FETCH:    state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (dec_illegal) state_next = FETCH;
        else begin
          unique case (op)
            OP_MEM:  state_next = MEMADR;
            OP_DP:   state_next = funct[5] ? EXECUTEI : EXECUTER;
            OP_BR:   state_next = BRANCH;
            default: state_next = FETCH;
          endcase
        end
      end
      MEMADR:   state_next = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_next = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_next = FETCH;
      MEMWRITE: state_next = (mem_ready || !cond_ex) ? FETCH : MEMWRITE;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      default:  state_next = FETCH;
    endcase
  end

  always_comb begin
    pc_write_d    = 1'b0;
    ir_write_d    = 1'b0;
    adr_src_d     = 1'b0;
    mem_write_d   = 1'b0;
    reg_write_d   = 1'b0;
    imm_src_d     = IMM_DP;
    alu_src_a_d   = 1'b0;
    alu_src_b_d   = SRCB_REG;
    alu_control_d = ALU_ADD;
    result_src_d  = RES_ALUOUT;
    illegal_d     = 1'b0;
    unique case (state)
      FETCH: begin
        ir_write_d   = mem_ready;
        pc_write_d   = mem_ready;
        alu_src_a_d  = 1'b1;
        alu_src_b_d  = SRCB_FOUR;
        result_src_d = RES_ALU;
      end
      DECODE: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = SRCB_FOUR;
        illegal_d   = dec_illegal;
      end
      MEMADR: begin
        alu_src_b_d   = SRCB_IMM;
        imm_src_d     = IMM_MEM;
        alu_control_d = funct[3] ? ALU_ADD : ALU_SUB;
      end
      MEMREAD: adr_src_d = 1'b1;
      MEMWB: begin
        result_src_d = RES_RDATA;
        reg_write_d  = cond_ex;
        pc_write_d   = cond_ex && rd_pc;
      end
      MEMWRITE: begin
        adr_src_d   = 1'b1;
        mem_write_d = cond_ex;
      end
      EXECUTER: alu_control_d = dp_alu_control(cmd);
      EXECUTEI: begin
        alu_src_b_d   = SRCB_IMM;
        imm_src_d     = IMM_DP;
        alu_control_d = dp_alu_control(cmd);
      end
      ALUWB: begin
        reg_write_d = cond_ex_q && !is_cmp;
        pc_write_d  = cond_ex_q && !is_cmp && rd_pc;
      end
      BRANCH: begin
        alu_src_b_d  = SRCB_IMM;
        imm_src_d    = IMM_BR;
        result_src_d = RES_ALU;
        pc_write_d   = cond_ex;
      end
      default: ;
    endcase
  end

  // Reset forces every control output low, including mem_ready-gated strobes.
  assign pc_write    = rst_n && pc_write_d;
  assign ir_write    = rst_n && ir_write_d;
  assign adr_src     = rst_n && adr_src_d;
  assign mem_write   = rst_n && mem_write_d;
  assign reg_write   = rst_n && reg_write_d;
  assign alu_src_a   = rst_n && alu_src_a_d;
  assign illegal     = rst_n && illegal_d;
  assign imm_src     = rst_n ? imm_src_d     : '0;
  assign alu_src_b   = rst_n ? alu_src_b_d   : '0;
  assign alu_control = rst_n ? alu_control_d : '0;
  assign result_src  = rst_n ? result_src_d  : '0;
  assign flags       = flags_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: an instruction-level model predicts the
// full output vector every cycle; literal checks pin key results.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] instr;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        pc_write, ir_write, adr_src, mem_write, reg_write;
  logic [1:0]  imm_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b, alu_control, result_src;
  logic [3:0]  flags;
  logic        illegal;

  multicycle_ctrl #(.FLAG_RST(4'b0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .alu_flags   (alu_flags),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .imm_src     (imm_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .result_src  (result_src),
    .flags       (flags),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] imm_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] result_src;
    logic [3:0] flags;
    logic       illegal;
  } outv_t;

  int    checks = 0;
  int    errors = 0;
  outv_t act, exp_cur;
  bit    exp_valid = 1'b0;
  string exp_name = "";
  logic [3:0] mflags;

  assign act = {pc_write, ir_write, adr_src, mem_write, reg_write, imm_src,
                alu_src_a, alu_src_b, alu_control, result_src, flags, illegal};

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (act !== exp_cur) begin
        errors++;
        $display("FAIL %s: got %b required %b", exp_name, act, exp_cur);
      end
    end
  end

  task automatic check_lit(input string nm, input logic [3:0] a, input logic [3:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b required %b", nm, a, e);
    end
  endtask

  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cy;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cy && !z;
      3'd5:    r = (n == v);
      3'd6:    r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    return c[0] ? !r : r;
  endfunction

  function automatic outv_t e_blank();
    outv_t e;
    e = '0;
    e.flags = mflags;
    return e;
  endfunction

  task automatic step(input string nm, input logic mr, input logic [3:0] af,
                      input logic [19:0] ins, input outv_t e);
    @(posedge clk);
    #1;
    mem_ready = mr;
    alu_flags = af;
    instr     = ins;
    exp_cur   = e;
    exp_name  = nm;
    exp_valid = 1'b1;
  endtask

  // One whole instruction: fetch stalls, then the phases its class implies.
  task automatic do_instr(input logic [19:0] ins, input logic [3:0] af,
                          input int fstall, input int mstall);
    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic [5:0] funct;
    bit pass, ill, cmp, arith;
    outv_t e;
    cond = ins[19:16]; op = ins[15:14]; funct = ins[13:8]; rd = ins[3:0];
    cmd = funct[4:1];
    for (int k = 0; k <= fstall; k++) begin
      e = e_blank();
      e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
      e.ir_write = (k == fstall); e.pc_write = (k == fstall);
      step("fetch", k == fstall, af, ins, e);
    end
    ill = (cond == 4'hF) || (op == 2'b11) ||
          (op == 2'b00 && !(cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010}));
    e = e_blank();
    e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.illegal = ill;
    step("decode", 1'b1, af, ins, e);
    if (ill) return;
    pass = cond_pass(cond, mflags);
    if (op == 2'b01) begin
      e = e_blank();
      e.alu_src_b = 2'b01; e.imm_src = 2'b01;
      e.alu_control = funct[3] ? 2'b00 : 2'b01;
      step("memadr", 1'b1, af, ins, e);
      if (funct[0]) begin
        for (int k = 0; k <= mstall; k++) begin
          e = e_blank(); e.adr_src = 1'b1;
          step("memread", k == mstall, af, ins, e);
        end
        e = e_blank();
        e.result_src = 2'b01; e.reg_write = pass; e.pc_write = pass && (rd == 4'd15);
        step("memwb", 1'b1, af, ins, e);
      end else if (!pass) begin
        e = e_blank(); e.adr_src = 1'b1;
        step("memwrite_skip", 1'b0, af, ins, e);
      end else begin
        for (int k = 0; k <= mstall; k++) begin
          e = e_blank(); e.adr_src = 1'b1; e.mem_write = 1'b1;
          step("memwrite", k == mstall, af, ins, e);
        end
      end
    end else if (op == 2'b10) begin
      e = e_blank();
      e.alu_src_b = 2'b01; e.imm_src = 2'b10; e.result_src = 2'b10; e.pc_write = pass;
      step("branch", 1'b1, af, ins, e);
    end else begin
      cmp   = (cmd == 4'b1010);
      arith = cmd inside {4'b0100, 4'b0010, 4'b1010};
      e = e_blank();
      e.alu_src_b = funct[5] ? 2'b01 : 2'b00;
      case (cmd)
        4'b0000: e.alu_control = 2'b10;
        4'b1100: e.alu_control = 2'b11;
        4'b0100: e.alu_control = 2'b00;
        default: e.alu_control = 2'b01;
      endcase
      step(funct[5] ? "executei" : "executer", 1'b1, af, ins, e);
      if (pass && (funct[0] || cmp)) begin
        mflags[3:2] = af[3:2];
        if (arith) mflags[1:0] = af[1:0];
      end
      e = e_blank();
      e.reg_write = pass && !cmp;
      e.pc_write  = pass && !cmp && (rd == 4'd15);
      step("aluwb", 1'b1, af, ins, e);
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; instr = '0; alu_flags = '0; mflags = 4'b0000;
    #3;
    check_lit("reset_strobes", {1'b0, pc_write, ir_write, mem_write}, 4'b0000);
    check_lit("reset_vector_zero", {3'b0, act == '0}, 4'd1);
    mem_ready = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;

    // ADD R1,R2,R3 interrupted by reset while in EXECUTER
    step("fetch", 1'b1, 4'h0, 20'hE0821, '{pc_write:1, ir_write:1, alu_src_a:1,
         alu_src_b:2'b10, result_src:2'b10, flags:4'h0, default:'0});
    step("decode", 1'b1, 4'h0, 20'hE0821, '{alu_src_a:1, alu_src_b:2'b10, flags:4'h0, default:'0});
    step("executer", 1'b1, 4'hF, 20'hE0821, '{flags:4'h0, default:'0});
    @(negedge clk); #1 exp_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_lit("midexec_reset_vector", {3'b0, act == '0}, 4'd1);
    check_lit("midexec_reset_flags", flags, 4'b0000);
    mem_ready = 1'b0;
    mflags = 4'b0000;
    @(negedge clk); #1 rst_n = 1'b1;

    do_instr(20'hE2921, 4'b0100, 3, 0);            // ADDS R1,R2,#5 after 3-cycle fetch stall
    check_lit("adds_flags", flags, 4'b0100);
    check_lit("adds_regwrite", {3'b0, reg_write}, 4'd1);
    do_instr(20'hE3510, 4'b0100, 0, 0);            // CMP sets Z
    check_lit("cmp_flags", flags, 4'b0100);
    check_lit("cmp_no_regwrite", {3'b0, reg_write}, 4'd0);
    do_instr(20'h0A800, 4'b0000, 0, 0);            // BEQ taken
    check_lit("beq_taken_pc", {3'b0, pc_write}, 4'd1);
    check_lit("beq_imm_src", {2'b0, imm_src}, 4'd2);
    do_instr(20'hE2510, 4'b0010, 0, 0);            // SUBS clears Z, sets C
    check_lit("subs_flags", flags, 4'b0010);
    do_instr(20'h0A800, 4'b0000, 0, 0);            // BEQ not taken
    check_lit("beq_nottaken_pc", {3'b0, pc_write}, 4'd0);
    do_instr(20'hE5932, 4'b0000, 0, 2);            // LDR U=1, 2 wait cycles
    check_lit("ldr_regwrite", {3'b0, reg_write}, 4'd1);
    check_lit("ldr_result_src", {2'b0, result_src}, 4'd1);
    do_instr(20'hE513F, 4'b0000, 0, 0);            // LDR U=0 into PC
    check_lit("ldr_pc_write", {3'b0, pc_write}, 4'd1);
    do_instr(20'hE3510, 4'b0110, 0, 0);            // CMP -> Z=1,C=1
    check_lit("cmp2_flags", flags, 4'b0110);
    do_instr(20'h15834, 4'b0000, 0, 0);            // STRNE with Z=1: no store
    check_lit("strne_no_write", {3'b0, mem_write}, 4'd0);
    do_instr(20'hE5834, 4'b0000, 0, 1);            // STR with 1 wait cycle
    do_instr(20'hE2101, 4'b1001, 0, 0);            // ANDS keeps C,V
    check_lit("ands_flags", flags, 4'b1010);
    do_instr(20'hE3801, 4'b0101, 0, 0);            // ORR without S
    check_lit("orr_flags_kept", flags, 4'b1010);
    do_instr(20'h02921, 4'b0100, 0, 0);            // ADDSEQ fails
    check_lit("addseq_fail_rw", {3'b0, reg_write}, 4'd0);
    check_lit("addseq_fail_flags", flags, 4'b1010);
    do_instr(20'hE3510, 4'b0100, 0, 0);            // CMP -> Z=1
    do_instr(20'h02521, 4'b0000, 0, 0);            // SUBSEQ clears Z, still writes back
    check_lit("subseq_self_rw", {3'b0, reg_write}, 4'd1);
    check_lit("subseq_self_flags", flags, 4'b0000);
    do_instr(20'hE241F, 4'b1111, 0, 0);            // SUB into PC
    check_lit("sub_pc_write", {3'b0, pc_write}, 4'd1);
    do_instr(20'hEC000, 4'b1111, 0, 0);            // op=11 illegal
    check_lit("illegal_op", {3'b0, illegal}, 4'd1);
    check_lit("illegal_op_flags", flags, 4'b0000);
    do_instr(20'hF0821, 4'b1111, 0, 0);            // cond=1111 illegal
    check_lit("illegal_cond", {3'b0, illegal}, 4'd1);
    do_instr(20'hE0221, 4'b1111, 0, 0);            // EOR unsupported
    check_lit("illegal_cmd", {3'b0, illegal}, 4'd1);
    do_instr(20'hEA800, 4'b0000, 10, 0);           // long fetch stall, then B
    check_lit("final_flags", flags, 4'b0000);

    @(negedge clk); #1 exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
